pipeline_sink: RTL
==================

PIPELINE_SINK -- requirements
Module: pipeline_sink

Interface
REQ-001 Parameter DATA_W, default 8: width of the stream data word.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of two, >= 2.
REQ-003 iCLOCK  in  1  sole clock; all state on rising edge.
REQ-004 iRESET  in  1  reset, asynchronous and active-high.
REQ-005 iRESET_SYNC  in  1  synchronous clear, active-high; same effect as iRESET at the next edge.
REQ-006 iPREV_VALID  in  1  upstream word valid.
REQ-007 oPREV_BUSY  out  1  backpressure to upstream.
REQ-008 iPREV_DATA  in  DATA_W  upstream word.
REQ-009 iRD_REQ  in  1  consumer pops the head word.
REQ-010 oRD_VALID  out  1  buffer non-empty; head word present.
REQ-011 oRD_DATA  out  DATA_W  head word (first-word-fall-through).
REQ-012 oCOUNT  out  clog2(DEPTH)+1  current occupancy.
REQ-013 oPROTO_ERR  out  1  sticky upstream protocol-violation flag.
REQ-014 oACCEPT_CNT  out  16  accepted-word counter (see Configuration).

Function
REQ-015 Push SHALL occur on a cycle with iPREV_VALID=1 and oPREV_BUSY=0; the word is written at the tail.
REQ-016 oPREV_BUSY SHALL be 1 exactly when occupancy == DEPTH, derived from registered state only; no combinational path from iRD_REQ or iPREV_VALID.
REQ-017 Pop SHALL occur on a cycle with iRD_REQ=1 and oRD_VALID=1; iRD_REQ while empty SHALL be ignored.
REQ-018 Push-to-oRD_VALID latency SHALL be 1 cycle when empty; oRD_DATA SHALL show the head word whenever oRD_VALID=1.
REQ-019 Simultaneous push and pop SHALL leave oCOUNT unchanged and preserve order.
REQ-020 When full, a pop in the same cycle SHALL NOT enable a push; oPREV_BUSY drops the following cycle.
REQ-021 Read/write pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH; full/empty SHALL come from oCOUNT, never pointer equality alone.
REQ-022 Protocol checker: if iPREV_VALID=1 and oPREV_BUSY=1 at an edge, then at the next edge iPREV_VALID=0 or a changed iPREV_DATA SHALL set oPROTO_ERR.
REQ-023 oPROTO_ERR SHALL stay set until reset.
REQ-024 Checker state machine: IDLE (no pending stalled word) -> STALL on valid&busy; STALL -> STALL while valid&busy with stable data; STALL -> IDLE on push; STALL -> ERROR on violation; ERROR absorbing until reset.

Reset
REQ-025 On iRESET or iRESET_SYNC: pointers and oCOUNT 0, oRD_VALID 0, oPREV_BUSY 0, oPROTO_ERR 0, checker IDLE, oACCEPT_CNT 0; oRD_DATA 0.
REQ-026 Reset mid-stream SHALL discard all buffered words; no push or pop SHALL occur in the reset cycle.
REQ-027 Buffer storage SHALL NOT require reset.

Configuration
REQ-028 Macro PIPELINE_SINK_STATS_EN defined: oACCEPT_CNT increments by 1 per push, saturating at 16'hFFFF.
REQ-029 Macro undefined: no counter register is built; oACCEPT_CNT SHALL be constant 0.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold the checker state enum (IDLE, STALL, ERROR) and the accept-counter width constant.
REQ-031 Storage SHALL be a sub-module pipeline_sink_ram: DEPTH x DATA_W, one write port, one asynchronous read port; all control stays in pipeline_sink.

Verification
REQ-032 Reset, then push 8'hA5 with iRD_REQ=0 -> next cycle oRD_VALID=1, oRD_DATA=8'hA5, oCOUNT=1.
REQ-033 Push 8'h01..8'h04 back-to-back, iRD_REQ=0 -> oCOUNT=4, oPREV_BUSY=1; a 5th offered word 8'h05 is not accepted and is held.
REQ-034 Full, assert iRD_REQ for 1 cycle with 8'h05 still offered -> pop 8'h01, no push that cycle; 8'h05 accepted next cycle; pops then yield 02,03,04,05.
REQ-035 Continuous push and pop for 20 words 8'h00..8'h13 -> order preserved, pointers wrap, oCOUNT stays 1, no oPROTO_ERR.
REQ-036 While oPREV_BUSY=1, change iPREV_DATA from 8'h10 to 8'h11 -> oPROTO_ERR=1 next cycle, stays 1 until iRESET.
REQ-037 With PIPELINE_SINK_STATS_EN: 3 pushes then iRESET_SYNC -> oACCEPT_CNT 3 then 0; without macro oACCEPT_CNT always 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline_sink stream buffer.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    ERROR = 2'd2
  } chk_state_e;

  localparam int ACCEPT_CNT_W = 16;

endpackage

// File: rtl/pipeline_sink_ram.sv
// Buffer storage for pipeline_sink: one write port, one asynchronous read port, no reset.
module pipeline_sink_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     iCLOCK,
  input  logic                     iWE,
  input  logic [$clog2(DEPTH)-1:0] iWADDR,
  input  logic [DATA_W-1:0]        iWDATA,
  input  logic [$clog2(DEPTH)-1:0] iRADDR,
  output logic [DATA_W-1:0]        oRDATA
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge iCLOCK) begin
    if (iWE) mem_q[iWADDR] <= iWDATA;
  end

  assign oRDATA = mem_q[iRADDR];

endmodule

// File: rtl/pipeline_sink.sv
// First-word-fall-through stream sink with backpressure and an upstream protocol checker.
// Define PIPELINE_SINK_STATS_EN to build the saturating accepted-word counter on oACCEPT_CNT.
module pipeline_sink
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                      iCLOCK,
  input  logic                      iRESET,
  input  logic                      iRESET_SYNC,
  input  logic                      iPREV_VALID,
  output logic                      oPREV_BUSY,
  input  logic [DATA_W-1:0]         iPREV_DATA,
  input  logic                      iRD_REQ,
  output logic                      oRD_VALID,
  output logic [DATA_W-1:0]         oRD_DATA,
  output logic [$clog2(DEPTH):0]    oCOUNT,
  output logic                      oPROTO_ERR,
  output logic [ACCEPT_CNT_W-1:0]   oACCEPT_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  chk_state_e        state_q, state_d;
  logic [DATA_W-1:0] stall_data_q, stall_data_d;
  logic [DATA_W-1:0] ram_rdata;
  logic              full, empty, push, pop;

  // Full/empty come from the occupancy register only, so busy has no input-to-output path.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = iPREV_VALID & ~full & ~iRESET_SYNC & ~iRESET;
  assign pop   = iRD_REQ & ~empty & ~iRESET_SYNC & ~iRESET;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (iRESET_SYNC) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_data_d = stall_data_q;
    case (state_q)
      IDLE: begin
        if (iPREV_VALID && full) begin
          state_d      = STALL;
          stall_data_d = iPREV_DATA;
        end
      end
      STALL: begin
        if (!iPREV_VALID || (iPREV_DATA != stall_data_q)) state_d = ERROR;
        else if (!full)                                   state_d = IDLE;
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (iRESET_SYNC) begin
      state_d      = IDLE;
      stall_data_d = '0;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      stall_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      stall_data_q <= stall_data_d;
    end
  end

  pipeline_sink_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .iCLOCK (iCLOCK),
    .iWE    (push),
    .iWADDR (wr_ptr_q),
    .iWDATA (iPREV_DATA),
    .iRADDR (rd_ptr_q),
    .oRDATA (ram_rdata)
  );

`ifdef PIPELINE_SINK_STATS_EN
  logic [ACCEPT_CNT_W-1:0] accept_cnt_q, accept_cnt_d;

  always_comb begin
    accept_cnt_d = accept_cnt_q;
    if (push && (accept_cnt_q != '1)) accept_cnt_d = accept_cnt_q + ACCEPT_CNT_W'(1);
    if (iRESET_SYNC) accept_cnt_d = '0;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) accept_cnt_q <= '0;
    else        accept_cnt_q <= accept_cnt_d;
  end

  assign oACCEPT_CNT = accept_cnt_q;
`else
  assign oACCEPT_CNT = '0;
`endif

  // Storage is never reset, so the head word is masked while the buffer is empty.
  assign oRD_DATA   = empty ? '0 : ram_rdata;
  assign oRD_VALID  = ~empty;
  assign oPREV_BUSY = full;
  assign oCOUNT     = count_q;
  assign oPROTO_ERR = (state_q == ERROR);

endmodule
